// File: rtl/ahb2apb_bridge_if.sv
// AHB-Lite slave / APB4 master signal bundle for the bridge.
// The slave modport is the bridge's view; master is the environment's view.
interface ahb2apb_bridge_if #(
    parameter int AWIDTH = 10,
    parameter int DSIZE  = 2
);
    localparam int DBYTES = 1 << DSIZE;
    localparam int DWIDTH = DBYTES * 8;

    // AHB side
    logic              hsel;
    logic              hready;
    logic [1:0]        htrans;
    logic [3:0]        hprot;
    logic [2:0]        hburst;
    logic [2:0]        hsize;
    logic              hmastlock;
    logic              hwrite;
    logic [AWIDTH-1:0] haddr;
    logic [DWIDTH-1:0] hwdata;
    logic [DWIDTH-1:0] hrdata;
    logic              hreadyout;
    logic              hresp;
    // APB side
    logic              psel;
    logic              penable;
    logic [2:0]        pprot;
    logic              pwrite;
    logic [AWIDTH-1:0] paddr;
    logic [DBYTES-1:0] pstrb;
    logic [DWIDTH-1:0] pwdata;
    logic [DWIDTH-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport slave (
        input  hsel, hready, htrans, hprot, hburst, hsize, hmastlock, hwrite,
        input  haddr, hwdata,
        output hrdata, hreadyout, hresp,
        output psel, penable, pprot, pwrite, paddr, pstrb, pwdata,
        input  prdata, pready, pslverr
    );

    modport master (
        output hsel, hready, htrans, hprot, hburst, hsize, hmastlock, hwrite,
        output haddr, hwdata,
        input  hrdata, hreadyout, hresp,
        input  psel, penable, pprot, pwrite, paddr, pstrb, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to APB4 bridge: one AHB beat becomes one APB SETUP/ACCESS pair,
// slave errors and oversized transfers come back as a two-cycle AHB ERROR.
module ahb2apb_bridge #(
    parameter int AWIDTH = 10,
    parameter int DSIZE  = 2
) (
    input  logic            xclk,
    input  logic            xresetn,
    ahb2apb_bridge_if.slave bus
);
    localparam int DBYTES = 1 << DSIZE;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t            state;
    logic              start;
    logic              size_ok;
    logic [DBYTES-1:0] strb_next;
    logic              unused_in;

    // Only NONSEQ/SEQ beats with the bus ready start a transfer
    assign start   = bus.hsel & bus.hready & bus.htrans[1];
    assign size_ok = (bus.hsize <= 3'(DSIZE));

    // AHB holds hwdata steady while we stall, so no capture register is needed
    assign bus.pwdata = bus.hwdata;

    // Burst type, lock and the cacheable/bufferable hints have no APB meaning
    assign unused_in = ^{bus.hburst, bus.hmastlock, bus.htrans[0], bus.hprot[3:2]};

    // Lane i is strobed when it shares the aligned 2^hsize-byte group with haddr
    always_comb begin
        strb_next = '0;
        for (int i = 0; i < DBYTES; i++) begin
            strb_next[i] = bus.hwrite && size_ok &&
                           (((DSIZE'(i) ^ bus.haddr[DSIZE-1:0]) >> bus.hsize) == '0);
        end
    end

    // Transfer sequencer with all AHB/APB outputs registered
    always_ff @(posedge xclk or negedge xresetn) begin
        if (!xresetn) begin
            state         <= IDLE;
            bus.hreadyout <= 1'b1;
            bus.hresp     <= 1'b0;
            bus.hrdata    <= '0;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.pwrite    <= 1'b0;
            bus.paddr     <= '0;
            bus.pstrb     <= '0;
            bus.pprot     <= '0;
        end else begin
            case (state)
                IDLE, ERR2: begin
                    state         <= IDLE;
                    bus.hreadyout <= 1'b1;
                    bus.hresp     <= 1'b0;
                    if (start) begin
                        bus.paddr     <= bus.haddr;
                        bus.pwrite    <= bus.hwrite;
                        bus.pprot     <= {~bus.hprot[0], 1'b0, bus.hprot[1]};
                        bus.pstrb     <= strb_next;
                        bus.hreadyout <= 1'b0;
                        if (size_ok) begin
                            state    <= SETUP;
                            bus.psel <= 1'b1;
                        end else begin
                            // Oversized beat: error without touching APB
                            state     <= ERR1;
                            bus.hresp <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.penable <= 1'b1;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        bus.psel    <= 1'b0;
                        bus.penable <= 1'b0;
                        if (bus.pslverr) begin
                            state     <= ERR1;
                            bus.hresp <= 1'b1;
                        end else begin
                            state         <= IDLE;
                            bus.hreadyout <= 1'b1;
                            if (!bus.pwrite) bus.hrdata <= bus.prdata;
                        end
                    end
                end
                ERR1: begin
                    state         <= ERR2;
                    bus.hreadyout <= 1'b1;
                    bus.hresp     <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    bus.hreadyout <= 1'b1;
                    bus.hresp     <= 1'b0;
                    bus.psel      <= 1'b0;
                    bus.penable   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Self-checking bench for ahb2apb_bridge: directed cases followed by random
// transfers, all checked against a transaction-level model of the bridge.
module tb_ahb2apb_bridge;
    localparam int AWIDTH = 10;
    localparam int DSIZE  = 2;
    localparam int DBYTES = 1 << DSIZE;

    logic xclk    = 1'b0;
    logic xresetn = 1'b0;

    int          checks     = 0;
    int          failures   = 0;
    logic [31:0] exp_hrdata = '0;

    always #5 xclk = ~xclk;

    ahb2apb_bridge_if #(.AWIDTH(AWIDTH), .DSIZE(DSIZE)) bus();

    ahb2apb_bridge #(.AWIDTH(AWIDTH), .DSIZE(DSIZE)) dut (
        .xclk    (xclk),
        .xresetn (xresetn),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobes: the aligned group of 2^size bytes containing addr, writes only
    function automatic logic [3:0] model_strb(input logic wr, input logic [9:0] addr, input int size);
        int nb;
        int base;
        if (!wr) return 4'b0000;
        nb   = 1 << size;
        base = (int'(addr) % DBYTES) / nb * nb;
        return 4'(((1 << nb) - 1) << base);
    endfunction

    // pprot bits: instruction when not a data access, always secure, privileged
    function automatic logic [2:0] model_prot(input logic [3:0] p);
        return {(p[0] == 1'b0), 1'b0, (p[1] == 1'b1)};
    endfunction

    // Runs one AHB beat starting in the current (ready) cycle; returns at the
    // last cycle of the response so the next beat can follow back-to-back.
    task automatic xfer(input logic wr, input logic [9:0] addr, input int size,
                        input logic [3:0] prot, input logic [31:0] wdata,
                        input int waits, input logic err, input logic [31:0] rdata);
        logic [3:0] es;
        logic [2:0] ep;
        es = model_strb(wr, addr, size);
        ep = model_prot(prot);
        chk("addr_phase_hreadyout", 32'(bus.hreadyout), 1);
        bus.hsel = 1'b1; bus.hready = 1'b1; bus.htrans = 2'b10;
        bus.hwrite = wr; bus.haddr = addr; bus.hsize = 3'(size); bus.hprot = prot;
        @(negedge xclk);
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = wdata;
        if (size > DSIZE) begin
            chk("badsize_err1_hreadyout", 32'(bus.hreadyout), 0);
            chk("badsize_err1_hresp",     32'(bus.hresp), 1);
            chk("badsize_err1_psel",      32'(bus.psel), 0);
            @(negedge xclk);
            chk("badsize_err2_hreadyout", 32'(bus.hreadyout), 1);
            chk("badsize_err2_hresp",     32'(bus.hresp), 1);
            chk("badsize_err2_psel",      32'(bus.psel), 0);
            return;
        end
        chk("setup_psel",      32'(bus.psel), 1);
        chk("setup_penable",   32'(bus.penable), 0);
        chk("setup_hreadyout", 32'(bus.hreadyout), 0);
        chk("setup_paddr",     32'(bus.paddr), 32'(addr));
        chk("setup_pwrite",    32'(bus.pwrite), 32'(wr));
        chk("setup_pstrb",     32'(bus.pstrb), 32'(es));
        chk("setup_pprot",     32'(bus.pprot), 32'(ep));
        for (int k = 0; k <= waits; k++) begin
            @(negedge xclk);
            chk("access_psel",      32'(bus.psel), 1);
            chk("access_penable",   32'(bus.penable), 1);
            chk("access_hreadyout", 32'(bus.hreadyout), 0);
            chk("access_paddr",     32'(bus.paddr), 32'(addr));
            chk("access_pwrite",    32'(bus.pwrite), 32'(wr));
            chk("access_pstrb",     32'(bus.pstrb), 32'(es));
            chk("access_pprot",     32'(bus.pprot), 32'(ep));
            chk("access_pwdata",    bus.pwdata, wdata);
            bus.pready  = (k == waits);
            bus.pslverr = err && (k == waits);
            bus.prdata  = (k == waits) ? rdata : $urandom;
        end
        @(negedge xclk);
        bus.pready = 1'b0; bus.pslverr = 1'b0;
        if (err) begin
            chk("err1_hreadyout", 32'(bus.hreadyout), 0);
            chk("err1_hresp",     32'(bus.hresp), 1);
            chk("err1_psel",      32'(bus.psel), 0);
            chk("err1_hrdata",    bus.hrdata, exp_hrdata);
            @(negedge xclk);
            chk("err2_hreadyout", 32'(bus.hreadyout), 1);
            chk("err2_hresp",     32'(bus.hresp), 1);
        end else begin
            if (!wr) exp_hrdata = rdata;
            chk("done_hreadyout", 32'(bus.hreadyout), 1);
            chk("done_hresp",     32'(bus.hresp), 0);
            chk("done_psel",      32'(bus.psel), 0);
            chk("done_penable",   32'(bus.penable), 0);
            chk("done_hrdata",    bus.hrdata, exp_hrdata);
        end
    endtask

    initial begin
        bus.hsel = 0; bus.hready = 1; bus.htrans = 0; bus.hprot = 0; bus.hburst = 0;
        bus.hsize = 0; bus.hmastlock = 0; bus.hwrite = 0; bus.haddr = 0; bus.hwdata = 0;
        bus.prdata = 0; bus.pready = 0; bus.pslverr = 0;

        // Reset values
        repeat (2) @(negedge xclk);
        chk("rst_hreadyout", 32'(bus.hreadyout), 1);
        chk("rst_hresp",     32'(bus.hresp), 0);
        chk("rst_hrdata",    bus.hrdata, 0);
        chk("rst_psel",      32'(bus.psel), 0);
        chk("rst_penable",   32'(bus.penable), 0);
        chk("rst_paddr",     32'(bus.paddr), 0);
        chk("rst_pstrb",     32'(bus.pstrb), 0);
        chk("rst_pprot",     32'(bus.pprot), 0);
        xresetn = 1'b1;
        @(negedge xclk);

        // Non-transfers: deselected, BUSY, and hready low
        bus.hsel = 0; bus.htrans = 2'b10; @(negedge xclk);
        chk("nosel_psel", 32'(bus.psel), 0);
        chk("nosel_hreadyout", 32'(bus.hreadyout), 1);
        bus.hsel = 1; bus.htrans = 2'b01; @(negedge xclk);
        chk("busy_psel", 32'(bus.psel), 0);
        chk("busy_hreadyout", 32'(bus.hreadyout), 1);
        bus.htrans = 2'b10; bus.hready = 0; @(negedge xclk);
        chk("nohready_psel", 32'(bus.psel), 0);
        bus.hsel = 0; bus.htrans = 2'b00; bus.hready = 1;
        @(negedge xclk);

        // Directed transfers
        xfer(1'b0, 10'h010, 2, 4'b0011, 32'h0, 0, 1'b0, 32'hCAFEF00D);
        @(negedge xclk);
        xfer(1'b1, 10'h006, 1, 4'b0001, 32'h1234_0000, 0, 1'b0, 32'h0);
        @(negedge xclk);
        xfer(1'b0, 10'h104, 2, 4'b0010, 32'h0, 3, 1'b0, 32'h0BAD_BEEF);
        @(negedge xclk);
        xfer(1'b0, 10'h200, 2, 4'b0000, 32'h0, 1, 1'b1, 32'hDEAD_0000);
        @(negedge xclk);
        xfer(1'b1, 10'h044, 3, 4'b0011, 32'h5555_AAAA, 0, 1'b0, 32'h0);
        @(negedge xclk);
        xfer(1'b1, 10'h013, 2, 4'b0001, 32'hA5A5_5A5A, 0, 1'b0, 32'h0);
        @(negedge xclk);
        xfer(1'b1, 10'h001, 0, 4'b0001, 32'h0000_7700, 0, 1'b0, 32'h0);
        @(negedge xclk);
        // Back-to-back writes, then a beat right after an error response
        xfer(1'b1, 10'h020, 2, 4'b0001, 32'h1111_1111, 0, 1'b0, 32'h0);
        xfer(1'b1, 10'h024, 2, 4'b0001, 32'h2222_2222, 0, 1'b0, 32'h0);
        xfer(1'b0, 10'h028, 2, 4'b0001, 32'h0, 0, 1'b1, 32'h0);
        xfer(1'b0, 10'h02C, 2, 4'b0001, 32'h0, 0, 1'b0, 32'h3333_3333);
        @(negedge xclk);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = int'($urandom_range(0, 1));
            repeat (gap) @(negedge xclk);
            xfer(1'($urandom_range(0, 1)), 10'($urandom), int'($urandom_range(0, 3)),
                 4'($urandom), $urandom, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) == 0), $urandom);
        end
        @(negedge xclk);

        // Asynchronous reset in the middle of ACCESS
        bus.hsel = 1; bus.htrans = 2'b10; bus.hwrite = 0; bus.haddr = 10'h3FC;
        bus.hsize = 3'd2; bus.hprot = 4'b0011;
        @(negedge xclk);
        bus.hsel = 0; bus.htrans = 2'b00; bus.pready = 0;
        @(negedge xclk);
        chk("pre_rst_penable", 32'(bus.penable), 1);
        xresetn = 1'b0;
        #1;
        chk("arst_psel",      32'(bus.psel), 0);
        chk("arst_penable",   32'(bus.penable), 0);
        chk("arst_hreadyout", 32'(bus.hreadyout), 1);
        chk("arst_hresp",     32'(bus.hresp), 0);
        chk("arst_hrdata",    bus.hrdata, 0);
        chk("arst_paddr",     32'(bus.paddr), 0);
        chk("arst_pwrite",    32'(bus.pwrite), 0);
        chk("arst_pprot",     32'(bus.pprot), 0);
        exp_hrdata = '0;
        @(negedge xclk);
        xresetn = 1'b1;
        @(negedge xclk);
        xfer(1'b0, 10'h0F0, 2, 4'b0001, 32'h0, 0, 1'b0, 32'h7654_3210);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
